// File: rtl/hex_scan_sched.sv
// Time-multiplexed scan scheduler for a multi-digit 7-segment display sharing one hex decoder.
// Each slot is BLANK dark cycles followed by lit cycles; data is snapshotted once per frame.
module hex_scan_sched #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dot_i,
  input  logic [DIGITS-1:0]     en_mask_i,
  input  logic                  lz_i,
  output logic [3:0]            nibble_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     hex_on_o,
  output logic                  frame_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(PRESCALE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  // With no dead time a slot begins directly in SHOW.
  localparam logic [1:0]       S_SLOT_START   = (BLANK == 0) ? S_SHOW : S_BLANK;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK - 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dot;
  logic                snap_lz;
  logic                frame_q;

  function automatic logic [IDX_W-1:0] lowest_bit(input logic [DIGITS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  // Returns {found, index} of the first set bit strictly above cur.
  function automatic logic [IDX_W:0] next_above(input logic [DIGITS-1:0] m,
                                                 input logic [IDX_W-1:0]  cur);
    logic             found;
    logic [IDX_W-1:0] r;
    found = 1'b0;
    r     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!found && m[k] && (k > int'(cur))) begin
        found = 1'b1;
        r     = IDX_W'(k);
      end
    end
    return {found, r};
  endfunction

  logic [IDX_W:0] nxt;
  assign nxt = next_above(en_mask_i, idx);

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      snap_data <= '0;
      snap_dot  <= '0;
      snap_lz   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|en_mask_i) begin
            state     <= S_SLOT_START;
            idx       <= lowest_bit(en_mask_i);
            cnt       <= '0;
            snap_data <= data_i;
            snap_dot  <= dot_i;
            snap_lz   <= lz_i;
          end
        end
        S_BLANK: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_BLANK_LAST) state <= S_SHOW;
        end
        S_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (en_mask_i == '0) begin
              state <= S_IDLE;
            end else begin
              state <= S_SLOT_START;
              if (nxt[IDX_W]) begin
                idx <= nxt[IDX_W-1:0];
              end else begin
                // Frame wrap: restart at the lowest enabled digit with fresh data.
                idx       <= lowest_bit(en_mask_i);
                frame_q   <= 1'b1;
                snap_data <= data_i;
                snap_dot  <= dot_i;
                snap_lz   <= lz_i;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [DIGITS-1:0] sup;
  logic [3:0]        cur_nib;
  logic              cur_dot;
  logic              cur_sup;
  logic              zero_run;
  logic              lit;

  // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
  always_comb begin
    sup      = '0;
    zero_run = snap_lz;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_data[4*k +: 4] == 4'h0);
      if (k > 0) sup[k] = zero_run;
    end
    cur_nib = '0;
    cur_dot = 1'b0;
    cur_sup = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib = snap_data[4*k +: 4];
        cur_dot = snap_dot[k];
        cur_sup = sup[k];
      end
    end
  end

  assign lit      = (state == S_SHOW) && !cur_sup;
  assign hex_on_o = lit ? (DIGITS'(1) << idx) : '0;
  assign nibble_o = lit ? cur_nib : 4'h0;
  assign dp_o     = lit ? cur_dot : 1'b0;
  assign frame_o  = frame_q;

endmodule

// File: doc/hex_scan_sched.md
# hex_scan_sched

Time-multiplexing scheduler for the board's multi-digit 7-segment display. It shares a single external hex decoder between DIGITS digit positions. Each digit gets an equal time slot, with a dead-time blanking interval at the start of every slot to prevent ghosting. The block supports per-digit enable masking, leading-zero suppression and tear-free frame snapshots. It sits between the counter/register datapath and the hex decoder plus digit-select pins.

## Interface
- DIGITS, 4, number of digit positions (2..8)
- PRESCALE, 50000, clock cycles per digit slot (PRESCALE > BLANK)
- BLANK, 16, dead-time cycles at slot start with all digits off (0 allowed)

- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-high
- data_i  in  4*DIGITS  nibble k = data_i[4k+3:4k] is shown on digit k
- dot_i  in  DIGITS  decimal point request per digit
- en_mask_i  in  DIGITS  1 = digit k is scheduled
- lz_i  in  1  leading-zero suppression enable
- nibble_o  out  4  value to the external hex decoder
- dp_o  out  1  decimal point of the lit digit
- hex_on_o  out  DIGITS  one-hot digit select, active-high, all-zero when dark
- frame_o  out  1  one-cycle pulse on frame wrap

## Operation
- States: IDLE, BLANK, SHOW. Registers: slot counter cnt (0..PRESCALE-1), digit index idx, snapshot of data_i/dot_i.
- All outputs are decoded from registered state only. There is no combinational path from input to output.
- IDLE: hex_on_o=0. If en_mask_i≠0 at a clock edge:
  - go to BLANK;
  - set idx = lowest set bit;
  - set cnt=0;
  - load the snapshot.
- BLANK: cnt increments each cycle; hex_on_o=0. When cnt reaches BLANK, go to SHOW. If BLANK=0, enter SHOW directly.
- SHOW: hex_on_o=1<<idx, nibble_o=snapshot[idx], dp_o=dot snapshot[idx], cnt increments.
- Slot end is the edge where cnt=PRESCALE-1. At slot end, en_mask_i is sampled:
  - mask=0: go to IDLE; no frame_o.
  - Otherwise the next idx is the next set bit above idx. If none exists, wrap to the lowest set bit: assert frame_o for one cycle and reload the snapshot.
  - Then go to BLANK with cnt=0.
- en_mask_i changes mid-slot do not affect the current slot. They take effect only at slot end.
- If the current idx is the only enabled digit, every slot end is a wrap: frame_o fires every PRESCALE cycles.
- Leading-zero suppression applies when lz_i=1 (sampled with the snapshot). Digit k>0 is suppressed if snapshot nibbles k..DIGITS-1 are all zero; the mask is ignored for this test.
  - A suppressed digit keeps its time slot, but hex_on_o stays 0 and dp_o=0 for the whole slot.
  - Digit 0 is never suppressed.
- nibble_o and dp_o are 0 whenever hex_on_o=0.

## Timing
- Reset values: state IDLE, cnt=0, idx=0, snapshot=0, nibble_o=0, dp_o=0, hex_on_o=0, frame_o=0.
- Reset asserted at any time forces all outputs to their reset values immediately (asynchronously).
- After reset release with mask≠0:
  - edge E0: IDLE→BLANK;
  - the first digit lights after edge E_BLANK, i.e. BLANK+1 edges after release.
- Slot length is exactly PRESCALE cycles: BLANK dark cycles followed by PRESCALE-BLANK lit cycles.
- Frame length is PRESCALE × popcount(mask) cycles.
- frame_o is high for the single cycle following the wrap edge, coincident with the first BLANK cycle of the new frame.
- data_i changes are visible only from the next snapshot load.

## Test plan
Parameters for all scenarios: DIGITS=4, PRESCALE=8, BLANK=2.
- Scan order: mask=1111, data=16'h1234, lz=0, release reset.
  - Each 8-cycle slot shows 2 dark cycles then 6 cycles of hex_on_o=0001/nibble 4, 0010/3, 0100/2, 1000/1.
  - frame_o pulses every 32 cycles.
- Masking: mask=0101. Only digits 0 and 2 are scanned; the frame is 16 cycles and hex_on_o never equals 0010 or 1000.
- Snapshot: switch data_i 16'h1234→16'hABCD during digit-1 SHOW.
  - Digits 2 and 3 still show 2 and 1.
  - The next frame shows D, C, B, A.
- Leading-zero suppression: lz=1.
  - data=16'h0050: digits 3 and 2 are dark for their full slots, digit 1 shows 5, digit 0 shows 0.
  - data=0: only digit 0 lights, showing 0.
- Mask drop: set mask=0000 mid-slot.
  - The current slot completes, then IDLE with hex_on_o=0 and no frame_o.
  - Set mask=0010: the next edge enters BLANK for digit 1 and lights it 2 cycles later.
- Async reset: assert rstn_i mid-SHOW.
  - hex_on_o, nibble_o, dp_o and frame_o go to 0 before the next clock edge.
  - After release, scanning restarts at the lowest enabled digit.
